// File: rtl/compare_pkg.sv
// compare_pkg
// Shared definitions for the magnitude comparators: the one-hot result codes
// ({gt, lt, eq}) used by both the single-cycle 8-bit comparator and the
// multi-cycle compare_seq_n, and the sequencer state encoding.
package compare_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_LT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the chunk index: clog2 of the chunk count, never below 1 bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/compare_chunk.sv
// compare_chunk
// Purely combinational CHUNK-bit unsigned comparator.
// Ports:
//   a_i    CHUNK-bit operand A slice
//   b_i    CHUNK-bit operand B slice
//   res_o  one-hot result: CMP_GT, CMP_LT or CMP_EQ
module compare_chunk
    import compare_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic [2:0]       res_o
);

    always_comb begin
        res_o = CMP_EQ;
        if (a_i > b_i) begin
            res_o = CMP_GT;
        end else if (a_i < b_i) begin
            res_o = CMP_LT;
        end
    end

endmodule

// File: rtl/compare_seq_n.sv
// compare_seq_n
// Multi-cycle WIDTH-bit magnitude comparator, unsigned or two's-complement.
// Compares CHUNK bits per clock from the most significant chunk down and stops
// at the first chunk that differs.
// Ports:
//   iClk     clock, rising edge
//   iRst     synchronous active-high reset
//   iStart   request, accepted in IDLE or DONE
//   iSigned  1 = two's-complement compare (sampled with iStart)
//   iData_a  operand A (sampled with iStart)
//   iData_b  operand B (sampled with iStart)
//   oBusy    high while in RUN
//   oDone    one-cycle pulse when oData holds a fresh result
//   oData    {gt, lt, eq} one-hot result, 3'b000 while no result is valid
//
// state | meaning
// IDLE  | waiting for iStart, oData holds the last result
// RUN   | comparing chunk idx, stepping toward chunk 0 while chunks are equal
// DONE  | result registered, oDone pulse; a new iStart is accepted here
module compare_seq_n
    import compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        data_q, data_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic [2:0]        chunk_res;
    logic [WIDTH-1:0]  sign_flip;

    // Flipping the MSB maps two's-complement onto offset binary, so the
    // chunk comparator only ever needs to do unsigned compares.
    assign sign_flip = {iSigned, {(WIDTH-1){1'b0}}};

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    compare_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i   (a_chunk),
        .b_i   (b_chunk),
        .res_o (chunk_res)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            data_q  <= CMP_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        data_d  = data_q;

        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    a_d     = iData_a ^ sign_flip;
                    b_d     = iData_b ^ sign_flip;
                    idx_d   = IDX_LAST;
                    data_d  = CMP_NONE;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (chunk_res != CMP_EQ) begin
                    data_d  = chunk_res;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    data_d  = CMP_EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oBusy = (state_q == RUN);
    assign oDone = (state_q == DONE);
    assign oData = data_q;

endmodule
